// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_P1,
    BOOTH_P2,
    BOOTH_M2,
    BOOTH_M1
  } booth_op_e;

  // Unsigned operands need one more group to consume the zero-extended top bits.
  function automatic int unsigned group_count(int unsigned width, logic is_signed);
    return is_signed ? width / 2 : width / 2 + 1;
  endfunction

  function automatic booth_op_e booth_decode(logic [2:0] grp);
    case (grp)
      3'b001, 3'b010: return BOOTH_P1;
      3'b011:         return BOOTH_P2;
      3'b100:         return BOOTH_M2;
      3'b101, 3'b110: return BOOTH_M1;
      default:        return BOOTH_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Start/ready/done handshake and operand/result bus of booth_seq_mult.
interface booth_seq_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, is_signed, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output ready, busy, done, product
  );
endinterface

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector over the (WIDTH+2)-bit extended multiplicand.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH+1:0]        a_ext,
  input  logic [2:0]              grp,
  output logic signed [WIDTH+1:0] pp
);

  booth_op_e        op;
  logic [WIDTH+1:0] a_x2;

  // A is extended by two bits, so doubling it never overflows.
  assign a_x2 = {a_ext[WIDTH:0], 1'b0};

  always_comb begin
    op = booth_decode(grp);
    pp = '0;
    unique case (op)
      BOOTH_ZERO: pp = '0;
      BOOTH_P1:   pp = a_ext;
      BOOTH_P2:   pp = a_x2;
      BOOTH_M2:   pp = -a_x2;
      BOOTH_M1:   pp = -a_ext;
      default:    pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth group retired per clock.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  booth_seq_mult_if.slave bus
);

  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned AW = 2 * WIDTH + 4;
  localparam int unsigned CW = $clog2(WIDTH / 2 + 2);

  state_e                state;
  logic [XW-1:0]         a_ext;
  logic [XW:0]           m_sr;
  logic                  sgn_q;
  logic [CW-1:0]         cnt;
  logic [AW-1:0]         acc;
  logic [AW-1:0]         acc_next;
  logic [AW-1:0]         pp_ext;
  logic signed [XW-1:0]  pp;
  logic                  last;
  logic                  ext_a;
  logic                  ext_b;

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .a_ext (a_ext),
    .grp   (m_sr[2:0]),
    .pp    (pp)
  );

  assign ext_a = bus.is_signed & bus.a[WIDTH-1];
  assign ext_b = bus.is_signed & bus.b[WIDTH-1];

  always_comb begin
    pp_ext   = {{(AW-XW){pp[XW-1]}}, pp};
    acc_next = acc + (pp_ext << {cnt, 1'b0});
    last     = (cnt == CW'(group_count(WIDTH, sgn_q) - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_ext       <= '0;
      m_sr        <= '0;
      sgn_q       <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      bus.product <= '0;
      bus.ready   <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_ext     <= {{2{ext_a}}, bus.a};
            m_sr      <= {{2{ext_b}}, bus.b, 1'b0};
            sgn_q     <= bus.is_signed;
            cnt       <= '0;
            acc       <= '0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next;
          m_sr <= {{2{m_sr[XW]}}, m_sr[XW:2]};
          cnt  <= cnt + 1'b1;
          // Final group: the product register takes the post-add value in the same edge.
          if (last) begin
            bus.product <= acc_next[2*WIDTH-1:0];
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            bus.ready   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_ready_busy_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.ready && bus.busy));

  a_done_single: assert property (@(posedge clk) disable iff (rst)
    bus.done |=> !bus.done);

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and randomized checks of booth_seq_mult at WIDTH 4, 8 and 16.
module tb_booth_seq_mult;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  booth_seq_mult_if #(.WIDTH(4))  if4  ();
  booth_seq_mult_if #(.WIDTH(8))  if8  ();
  booth_seq_mult_if #(.WIDTH(16)) if16 ();

  booth_seq_mult #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
  booth_seq_mult #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  booth_seq_mult #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product of the operands as interpreted by mode.
  function automatic logic [31:0] ref_mul(int w, logic sg, logic [15:0] av, logic [15:0] bv);
    longint x, y, m;
    m = (longint'(1) << w) - 1;
    x = longint'(av) & m;
    y = longint'(bv) & m;
    if (sg && x[w-1]) x -= longint'(1) << w;
    if (sg && y[w-1]) y -= longint'(1) << w;
    return 32'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int exp_lat(int w, logic sg);
    return sg ? w / 2 : w / 2 + 1;
  endfunction

  function automatic logic [15:0] pick(int w);
    logic [15:0] m;
    m = 16'((32'd1 << w) - 1);
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return m;
      2:       return 16'(32'd1 << (w - 1));
      3:       return 16'((32'd1 << (w - 1)) - 1);
      default: return 16'($urandom) & m;
    endcase
  endfunction

  task automatic drive(int w, logic st, logic sg, logic [15:0] av, logic [15:0] bv);
    case (w)
      4: begin
        if4.start = st; if4.is_signed = sg; if4.a = av[3:0]; if4.b = bv[3:0];
      end
      8: begin
        if8.start = st; if8.is_signed = sg; if8.a = av[7:0]; if8.b = bv[7:0];
      end
      default: begin
        if16.start = st; if16.is_signed = sg; if16.a = av; if16.b = bv;
      end
    endcase
  endtask

  function automatic logic done_of(int w);
    case (w)
      4: return if4.done;
      8: return if8.done;
      default: return if16.done;
    endcase
  endfunction

  function automatic logic ready_of(int w);
    case (w)
      4: return if4.ready;
      8: return if8.ready;
      default: return if16.ready;
    endcase
  endfunction

  function automatic logic busy_of(int w);
    case (w)
      4: return if4.busy;
      8: return if8.busy;
      default: return if16.busy;
    endcase
  endfunction

  function automatic logic [31:0] prod_of(int w);
    case (w)
      4: return {24'd0, if4.product};
      8: return {16'd0, if8.product};
      default: return if16.product;
    endcase
  endfunction

  task automatic wait_done(int w, bit chk, output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done_of(w)) begin
        lat = c;
        break;
      end
      if (chk) begin
        check("ready_low", 64'(ready_of(w)), 0);
        check("busy_high", 64'(busy_of(w)), 1);
      end
    end
    if (lat == 0) check("done_timeout", 64'(done_of(w)), 1);
  endtask

  task automatic do_op(int w, logic sg, logic [15:0] av, logic [15:0] bv, bit chk,
                       output int lat, output logic [31:0] p);
    for (int c = 0; c < 40 && !ready_of(w); c++) begin
      @(posedge clk); #1;
    end
    drive(w, 1'b1, sg, av, bv);
    @(posedge clk); #1;
    drive(w, 1'b0, ~sg, 16'($urandom), 16'($urandom));
    if (chk) check("ready_e0", 64'(ready_of(w)), 0);
    wait_done(w, chk, lat);
    p = prod_of(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          ndone;
    int          ws[3];
    logic [31:0] p;
    logic [15:0] av, bv;
    logic        sg;

    ws = '{4, 8, 16};
    rst = 1'b1;
    drive(4, 0, 0, 0, 0);
    drive(8, 0, 0, 0, 0);
    drive(16, 0, 0, 0, 0);
    #12;
    check("rst_ready", 64'(if8.ready), 1);
    check("rst_busy", 64'(if8.busy), 0);
    check("rst_done", 64'(if8.done), 0);
    check("rst_product", 64'(if8.product), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 7 * -3 signed
    do_op(8, 1'b1, 16'd7, 16'hFFFD, 1, lat, p);
    check("t1_prod", p, 32'hFFEB);
    check("t1_lat", lat, 4);
    @(posedge clk); #1;
    check("t1_done_pulse", 64'(done_of(8)), 0);

    // -128 * -128 signed
    do_op(8, 1'b1, 16'h0080, 16'h0080, 1, lat, p);
    check("t2_prod", p, 32'h4000);
    check("t2_lat", lat, 4);

    // 0xFF * 0xFF unsigned, then the same bits signed
    do_op(8, 1'b0, 16'h00FF, 16'h00FF, 1, lat, p);
    check("t3u_prod", p, 32'hFE01);
    check("t3u_lat", lat, 5);
    do_op(8, 1'b1, 16'h00FF, 16'h00FF, 1, lat, p);
    check("t3s_prod", p, 32'h0001);
    check("t3s_lat", lat, 4);

    // start while busy must be ignored
    @(posedge clk); #1;
    drive(8, 1'b1, 1'b1, 16'd3, 16'd5);
    @(posedge clk); #1;
    drive(8, 1'b1, 1'b1, 16'd100, 16'd77);
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 3) drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      if (done_of(8)) ndone++;
    end
    check("t4_done_count", ndone, 1);
    check("t4_prod", prod_of(8), 15);

    // asynchronous reset two cycles into an operation
    drive(8, 1'b1, 1'b1, 16'd9, 16'd11);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("t5_ready", 64'(if8.ready), 1);
    check("t5_busy", 64'(if8.busy), 0);
    check("t5_done", 64'(if8.done), 0);
    check("t5_product", 64'(if8.product), 0);
    #2 rst = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done_of(8)) ndone++;
    end
    check("t5_no_done", ndone, 0);
    do_op(8, 1'b1, 16'd9, 16'd11, 1, lat, p);
    check("t5_after_prod", p, 99);

    // back-to-back: second start while done is high
    @(posedge clk); #1;
    drive(8, 1'b1, 1'b1, 16'd2, 16'd3);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    wait_done(8, 1, lat);
    check("t6a_lat", lat, 4);
    check("t6a_prod", prod_of(8), 6);
    drive(8, 1'b1, 1'b1, 16'h00FF, 16'h00FF);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    check("t6_hold_prod", prod_of(8), 6);
    check("t6_hold_done", 64'(done_of(8)), 0);
    check("t6_hold_busy", 64'(busy_of(8)), 1);
    wait_done(8, 0, lat);
    check("t6b_lat", lat, 4);
    check("t6b_prod", prod_of(8), 1);

    // randomized sweep over widths, modes and operand corners
    foreach (ws[i]) begin
      for (int k = 0; k < 40; k++) begin
        sg = 1'($urandom_range(0, 1));
        av = pick(ws[i]);
        bv = pick(ws[i]);
        do_op(ws[i], sg, av, bv, 0, lat, p);
        check($sformatf("rnd%0d_prod a=%0h b=%0h s=%0d", ws[i], av, bv, sg), p,
              ref_mul(ws[i], sg, av, bv));
        check($sformatf("rnd%0d_lat", ws[i]), lat, exp_lat(ws[i], sg));
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk); #1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
